// File: rtl/cam_cfg_pkg.sv
// Shared constants for the camera config sequencer: FSM state codes, default
// table tags and a helper that derives tag values for any entry width.
package cam_cfg_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_ADVANCE = 3'd5;
    localparam logic [2:0] ST_FINISH  = 3'd6;

    localparam logic [15:0] DEF_DELAY_TAG = 16'hFFF0;
    localparam logic [15:0] DEF_END_TAG   = 16'hFFFF;

    // A 16-bit entry uses the tag as given; other widths keep the tag's
    // distance below all-ones (END = all-ones, DELAY = all-ones minus 15).
    function automatic logic [63:0] tag_value(input int unsigned width, input logic [15:0] tag16);
        if (width == 16)
            return {48'd0, tag16};
        return ((64'd1 << width) - 64'd1) - {48'd0, 16'hFFFF - tag16};
    endfunction

endpackage

// File: rtl/cam_cfg_sequencer_if.sv
// Table-ROM read port and SCCB write handshake seen by the config sequencer.
interface cam_cfg_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int REG_W  = 8,
    parameter int VAL_W  = 8
);
    logic [ADDR_W-1:0]      rom_addr;
    logic [REG_W+VAL_W-1:0] rom_data;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [REG_W-1:0]       wr_reg;
    logic [VAL_W-1:0]       wr_val;

    modport master (
        output rom_addr, wr_valid, wr_reg, wr_val,
        input  rom_data, wr_ready
    );

    modport slave (
        input  rom_addr, wr_valid, wr_reg, wr_val,
        output rom_data, wr_ready
    );
endinterface

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter with a zero flag; times both the ROM read latency
// and the DELAY_TAG pause.
module cfg_delay_timer #(
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks a {reg, value} config table from a base address, honours DELAY/END
// tags and hands each write to the SCCB master over valid/ready.
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          REG_W     = 8,
    parameter int          VAL_W     = 8,
    parameter logic [15:0] DELAY_TAG = DEF_DELAY_TAG,
    parameter logic [15:0] END_TAG   = DEF_END_TAG,
    parameter int          DELAY_CYC = 1_250_000,
    parameter int          ROM_LAT   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_table_base,
    cam_cfg_sequencer_if.master bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [ADDR_W:0]     o_wr_count
);
    localparam int DW    = REG_W + VAL_W;
    localparam int CNT_W = ($clog2(DELAY_CYC + 1) > 2) ? $clog2(DELAY_CYC + 1) : 2;

    localparam logic [DW-1:0]    L_END_TAG   = DW'(tag_value(DW, END_TAG));
    localparam logic [DW-1:0]    L_DELAY_TAG = DW'(tag_value(DW, DELAY_TAG));
    localparam logic [CNT_W-1:0] L_DLY_LOAD  = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] L_LAT_LOAD  = CNT_W'(ROM_LAT - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_wr_valid;
    logic [REG_W-1:0]  r_wr_reg;
    logic [VAL_W-1:0]  r_wr_val;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_wr_count;

    logic              w_is_end;
    logic              w_is_delay;
    logic              w_last_addr;
    logic              w_tmr_load;
    logic [CNT_W-1:0]  w_tmr_load_val;
    logic              w_tmr_dec;
    logic              w_tmr_zero;

    assign w_is_end    = (bus.rom_data == L_END_TAG);
    assign w_is_delay  = (bus.rom_data == L_DELAY_TAG) && !w_is_end;
    assign w_last_addr = (r_rom_addr == '1);

    // The shared timer is loaded on every entry into FETCH and into WAIT.
    assign w_tmr_load = ((r_state == ST_IDLE)    && i_start) ||
                        ((r_state == ST_ADVANCE) && !w_last_addr) ||
                        ((r_state == ST_DECODE)  && w_is_delay);
    assign w_tmr_load_val = (r_state == ST_DECODE) ? L_DLY_LOAD : L_LAT_LOAD;
    assign w_tmr_dec      = (r_state == ST_FETCH) || (r_state == ST_WAIT);

    cfg_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rom_addr <= '0;
            r_wr_valid <= 1'b0;
            r_wr_reg   <= '0;
            r_wr_val   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_rom_addr <= i_table_base;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_wr_count <= '0;
                    r_busy     <= 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_FETCH: if (w_tmr_zero) r_state <= ST_DECODE;
                // busy/done flip on entry so the FINISH cycle already reports completion
                ST_DECODE: if (w_is_end) begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_FINISH;
                end else if (w_is_delay) begin
                    r_state <= ST_WAIT;
                end else begin
                    r_wr_reg   <= bus.rom_data[DW-1 -: REG_W];
                    r_wr_val   <= bus.rom_data[VAL_W-1:0];
                    r_wr_valid <= 1'b1;
                    r_state    <= ST_WRITE;
                end
                ST_WRITE: if (bus.wr_ready) begin
                    r_wr_valid <= 1'b0;
                    if (r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
                    r_state    <= ST_ADVANCE;
                end
                ST_WAIT: if (w_tmr_zero) r_state <= ST_ADVANCE;
                ST_ADVANCE: if (w_last_addr) begin
                    r_err   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_FINISH;
                end else begin
                    r_rom_addr <= r_rom_addr + 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rom_addr = r_rom_addr;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_reg   = r_wr_reg;
    assign bus.wr_val   = r_wr_val;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_wr_count   = r_wr_count;
endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Scoreboard bench: two sequencer instances (8-bit and 4-bit address) fed by
// table-ROM models; expected writes are queued at stimulus time.
module tb_cam_cfg_sequencer;
    localparam int DLY = 20;

    logic clk;
    logic rst_n;

    logic       start_a, start_b;
    logic [7:0] base_a;
    logic [3:0] base_b;
    logic       busy_a, done_a, err_a;
    logic       busy_b, done_b, err_b;
    logic [8:0] cnt_a;
    logic [4:0] cnt_b;

    logic [15:0] rom_a [256];
    logic [15:0] rom_b [16];
    logic [15:0] exp_q_a [$];
    logic [15:0] exp_q_b [$];

    int n_total = 0;
    int n_pass  = 0;

    cam_cfg_sequencer_if #(.ADDR_W(8), .REG_W(8), .VAL_W(8)) if_a ();
    cam_cfg_sequencer_if #(.ADDR_W(4), .REG_W(8), .VAL_W(8)) if_b ();

    cam_cfg_sequencer #(.ADDR_W(8), .DELAY_CYC(DLY), .ROM_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(start_a), .i_table_base(base_a), .bus(if_a),
        .o_busy(busy_a), .o_done(done_a), .o_err(err_a), .o_wr_count(cnt_a)
    );

    cam_cfg_sequencer #(.ADDR_W(4), .DELAY_CYC(DLY), .ROM_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(start_b), .i_table_base(base_b), .bus(if_b),
        .o_busy(busy_b), .o_done(done_b), .o_err(err_b), .o_wr_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous table ROMs
    always @(posedge clk) if_a.rom_data <= rom_a[if_a.rom_addr];
    always @(posedge clk) if_b.rom_data <= rom_b[if_b.rom_addr];

    always @(negedge clk) begin
        if (rst_n && if_a.wr_valid && if_a.wr_ready) begin
            n_total++;
            if (exp_q_a.size() == 0) begin
                $display("FAIL wr_a_unexpected: got %h%h expected no write", if_a.wr_reg, if_a.wr_val);
            end else begin
                logic [15:0] e;
                e = exp_q_a.pop_front();
                if ({if_a.wr_reg, if_a.wr_val} !== e)
                    $display("FAIL wr_a_data: got %h%h expected %h", if_a.wr_reg, if_a.wr_val, e);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if_b.wr_valid && if_b.wr_ready) begin
            n_total++;
            if (exp_q_b.size() == 0) begin
                $display("FAIL wr_b_unexpected: got %h%h expected no write", if_b.wr_reg, if_b.wr_val);
            end else begin
                logic [15:0] e;
                e = exp_q_b.pop_front();
                if ({if_b.wr_reg, if_b.wr_val} !== e)
                    $display("FAIL wr_b_data: got %h%h expected %h", if_b.wr_reg, if_b.wr_val, e);
                else n_pass++;
            end
        end
    end

    task automatic pulse_start(input bit use_b, input logic [7:0] base);
        @(posedge clk); #1;
        if (use_b) begin start_b = 1'b1; base_b = base[3:0]; end
        else begin start_a = 1'b1; base_a = base; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit use_b, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = use_b ? (done_b && !busy_b) : (done_a && !busy_a);
        end
        n_total++;
        if (!ok) $display("FAIL %s_timeout: got no done within %0d cycles expected done", name, budget);
        else n_pass++;
    endtask

    task automatic check_queues(input string name);
        n_total++;
        if (exp_q_a.size() + exp_q_b.size() != 0)
            $display("FAIL %s_pending: got %0d writes outstanding expected 0", name, exp_q_a.size() + exp_q_b.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; base_a = '0; base_b = '0;
        if_a.wr_ready = 1'b0; if_b.wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({if_a.wr_valid, busy_a, done_a, err_a, cnt_a, if_a.rom_addr, if_a.wr_reg, if_a.wr_val} !== '0)
            $display("FAIL reset_a: got v%b b%b d%b e%b c%0d a%h expected all zero",
                     if_a.wr_valid, busy_a, done_a, err_a, cnt_a, if_a.rom_addr);
        else n_pass++;
        n_total++;
        if ({if_b.wr_valid, busy_b, done_b, err_b, cnt_b, if_b.rom_addr} !== '0)
            $display("FAIL reset_b: got v%b b%b d%b e%b c%0d a%h expected all zero",
                     if_b.wr_valid, busy_b, done_b, err_b, cnt_b, if_b.rom_addr);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int busy_cyc;
        rom_a[0] = 16'h1280; rom_a[1] = 16'h1204; rom_a[2] = 16'hFFFF;
        if_a.wr_ready = 1'b1;
        exp_q_a.push_back(16'h1280);
        exp_q_a.push_back(16'h1204);
        pulse_start(1'b0, 8'd0);
        busy_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_a) break;
            busy_cyc++;
        end
        n_total++;
        if (busy_cyc != 10) $display("FAIL basic_busy_len: got %0d cycles expected 10", busy_cyc);
        else n_pass++;
        n_total++;
        if ({done_a, err_a, cnt_a} !== {1'b1, 1'b0, 9'd2})
            $display("FAIL basic_status: got done=%b err=%b cnt=%0d expected done=1 err=0 cnt=2", done_a, err_a, cnt_a);
        else n_pass++;
        check_queues("basic");
    endtask

    task automatic test_backpressure();
        bit seen;
        rom_a[16] = 16'h3355; rom_a[17] = 16'hFFFF;
        if_a.wr_ready = 1'b0;
        exp_q_a.push_back(16'h3355);
        pulse_start(1'b0, 8'd16);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = if_a.wr_valid;
        end
        n_total++;
        if (!seen) $display("FAIL bp_valid_rise: got wr_valid=0 expected 1 within 20 cycles");
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_total++;
            if ({if_a.wr_valid, if_a.wr_reg, if_a.wr_val} !== {1'b1, 8'h33, 8'h55})
                $display("FAIL bp_hold_%0d: got v=%b %h%h expected v=1 3355", i, if_a.wr_valid, if_a.wr_reg, if_a.wr_val);
            else n_pass++;
        end
        @(posedge clk); #1;
        if_a.wr_ready = 1'b1;
        wait_done(1'b0, 40, "bp");
        n_total++;
        if (cnt_a !== 9'd1) $display("FAIL bp_count: got %0d expected 1", cnt_a);
        else n_pass++;
        check_queues("bp");
    endtask

    task automatic test_delay();
        bit seen;
        int k;
        rom_a[32] = 16'hFFF0; rom_a[33] = 16'h1180; rom_a[34] = 16'hFFFF;
        if_a.wr_ready = 1'b1;
        exp_q_a.push_back(16'h1180);
        pulse_start(1'b0, 8'd32);
        seen = 1'b0;
        k = -1;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            k = i;
            seen = if_a.wr_valid;
        end
        // Cycle 0 is the first FETCH; FETCH+DECODE precede WAIT, then DLY WAIT cycles plus ADVANCE, FETCH, DECODE
        n_total++;
        if (!seen || k != 2 + DLY + 3)
            $display("FAIL delay_latency: got cycle %0d (seen=%b) expected %0d", k, seen, 2 + DLY + 3);
        else n_pass++;
        wait_done(1'b0, 40, "delay");
        n_total++;
        if (cnt_a !== 9'd1) $display("FAIL delay_count: got %0d expected 1", cnt_a);
        else n_pass++;
        check_queues("delay");
    endtask

    task automatic test_overrun();
        bit hit_zero, ok;
        rom_b[14] = 16'h2101; rom_b[15] = 16'h2202; rom_b[0] = 16'h2A2A;
        if_b.wr_ready = 1'b1;
        exp_q_b.push_back(16'h2101);
        exp_q_b.push_back(16'h2202);
        pulse_start(1'b1, 8'd14);
        hit_zero = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (if_b.rom_addr == 4'd0) hit_zero = 1'b1;
            ok = done_b && !busy_b;
        end
        n_total++;
        if ({ok, done_b, err_b, cnt_b} !== {1'b1, 1'b1, 1'b1, 5'd2})
            $display("FAIL overrun_status: got fin=%b done=%b err=%b cnt=%0d expected 1 1 1 2", ok, done_b, err_b, cnt_b);
        else n_pass++;
        n_total++;
        if (hit_zero) $display("FAIL overrun_wrap: got rom_addr=0 during run expected never");
        else n_pass++;
        check_queues("overrun");
    endtask

    task automatic test_restart();
        rom_a[48] = 16'h4444; rom_a[49] = 16'h4545; rom_a[50] = 16'hFFFF;
        if_a.wr_ready = 1'b1;
        exp_q_a.push_back(16'h4444);
        exp_q_a.push_back(16'h4545);
        pulse_start(1'b0, 8'd48);
        repeat (2) @(negedge clk);
        pulse_start(1'b0, 8'd0);
        wait_done(1'b0, 40, "restart_first");
        n_total++;
        if (cnt_a !== 9'd2) $display("FAIL restart_first_count: got %0d expected 2", cnt_a);
        else n_pass++;
        exp_q_a.push_back(16'h3355);
        pulse_start(1'b0, 8'd16);
        @(negedge clk);
        n_total++;
        if ({busy_a, done_a, cnt_a} !== {1'b1, 1'b0, 9'd0})
            $display("FAIL restart_clear: got busy=%b done=%b cnt=%0d expected 1 0 0", busy_a, done_a, cnt_a);
        else n_pass++;
        wait_done(1'b0, 40, "restart_second");
        n_total++;
        if ({done_a, err_a, cnt_a} !== {1'b1, 1'b0, 9'd1})
            $display("FAIL restart_second_status: got done=%b err=%b cnt=%0d expected 1 0 1", done_a, err_a, cnt_a);
        else n_pass++;
        check_queues("restart");
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        rom_a[64] = 16'h5566; rom_a[65] = 16'hFFFF;
        if_a.wr_ready = 1'b0;
        pulse_start(1'b0, 8'd64);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = if_a.wr_valid;
        end
        n_total++;
        if (!seen) $display("FAIL rstmid_valid_rise: got wr_valid=0 expected 1");
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({if_a.wr_valid, busy_a, done_a, err_a, cnt_a, if_a.rom_addr, if_a.wr_reg, if_a.wr_val} !== '0)
            $display("FAIL rstmid_async: got v=%b busy=%b cnt=%0d addr=%h expected all zero",
                     if_a.wr_valid, busy_a, cnt_a, if_a.rom_addr);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if_a.wr_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_total++;
        if ({if_a.wr_valid, busy_a, done_a, cnt_a} !== '0)
            $display("FAIL rstmid_idle: got v=%b busy=%b done=%b cnt=%0d expected all zero",
                     if_a.wr_valid, busy_a, done_a, cnt_a);
        else n_pass++;
        check_queues("rstmid");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
        for (int i = 0; i < 16; i++)  rom_b[i] = 16'hFFFF;
        test_reset();
        test_basic();
        test_backpressure();
        test_delay();
        test_overrun();
        test_restart();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish before 200000");
        $fatal(1);
    end
endmodule
